// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and helpers for the multi-port register file
//
// Purpose : state encoding for the clear sequencer, address-width helper and
//           the hardwired-zero register address.
// Ports   : none (package).
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  localparam int RF_ZERO_ADDR = 0;

  // Address width for n registers; never returns less than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - clear sequencer that zeroes the array after reset or on request
//
// Purpose : walks every register index once, asserting clr_we, then reports
//           ready. A clr_req sampled while ready restarts the walk; a clr_req
//           sampled mid-walk is ignored.
// Ports   :
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset (restarts the walk at 0)
//   clr_req  in   request to re-zero the array (honoured only when ready)
//   ready    out  high when the array is usable (registered)
//   clr_we   out  write-zero strobe for the array, high while clearing
//   clr_idx  out  register index being zeroed this cycle
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  rf_state_t         r_state;
  rf_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RF_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    clr_we      = 1'b0;
    case (r_state)
      RF_CLEAR: begin
        clr_we = 1'b1;
        // The edge that zeroes the last index is the one that raises ready.
        if (r_idx == LAST_IDX) begin
          w_state_nxt = RF_READY;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      RF_READY: begin
        if (clr_req) begin
          w_state_nxt = RF_CLEAR;
          w_idx_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = RF_CLEAR;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign ready   = (r_state == RF_READY);
  assign clr_idx = r_idx;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with zero register and clear sequencer
//
// Purpose : NUM_REGS x DATA_W array, NUM_RD combinational read ports and
//           NUM_WR synchronous write ports. Register 0 reads as zero, the
//           higher-indexed writer wins on an address collision, and all reads
//           return zero while the array is being cleared.
// Option  : REGFILE_BYPASS_EN - when defined, a read whose address matches an
//           accepted write in the same cycle returns the write data.
// Ports   :
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   clr_req  in   request to re-zero the whole array
//   ready    out  high when the array is usable
//   rd_addr  in   NUM_RD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  out  NUM_RD packed read data, port i at [i*DATA_W +: DATA_W]
//   wr_en    in   per-port write enable
//   wr_addr  in   NUM_WR packed write addresses
//   wr_data  in   NUM_WR packed write data
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  localparam int ADDR_W  = addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr_req,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_ADDR);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_idx;

  logic [ADDR_W-1:0] w_wr_addr [NUM_WR];
  logic [DATA_W-1:0] w_wr_data [NUM_WR];
  logic [NUM_WR-1:0] w_wr_acc;

  regfile_clear_seq #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_clear_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_req (clr_req),
    .ready   (ready),
    .clr_we  (w_clr_we),
    .clr_idx (w_clr_idx)
  );

  // A write is accepted only when the array is usable, no clear is being
  // requested on this edge, and it does not target the zero register.
  for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
    assign w_wr_addr[w] = wr_addr[w*ADDR_W +: ADDR_W];
    assign w_wr_data[w] = wr_data[w*DATA_W +: DATA_W];
    assign w_wr_acc[w]  = wr_en[w] & ready & ~clr_req & (w_wr_addr[w] != ZERO_ADDR);
  end

  // Later loop iterations override earlier ones, so the higher-indexed port
  // wins when two writers hit the same address.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_idx] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (w_wr_acc[w]) begin
          r_mem[w_wr_addr[w]] <= w_wr_data[w];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_val;

    assign w_addr = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      w_val = '0;
      if (ready && (w_addr != ZERO_ADDR)) begin
        w_val = r_mem[w_addr];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++) begin
          if (w_wr_acc[w] && (w_wr_addr[w] == w_addr)) begin
            w_val = w_wr_data[w];
          end
        end
`endif
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = w_val;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file. Successor to the single-cycle core's 2-read/1-write register file.
- Generalises data width, register count, read-port count and write-port count.
- Adds a hardwired zero register, deterministic multi-writer priority, and a clear sequencer that zeroes the array after reset or on request, with a ready flag.
- Sits in the datapath between decode (addresses) and ALU/writeback (data).

Parameters:
- DATA_W, 32, width of each register in bits.
- NUM_REGS, 32, number of registers; power of two, minimum 4.
- NUM_RD, 2, number of asynchronous read ports, 1..4.
- NUM_WR, 1, number of synchronous write ports, 1..2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clr_req  input  1  synchronous request to re-zero the whole array.
- ready  output  1  high when the array is usable; low while clearing.
- rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]. ADDR_W = clog2(NUM_REGS).
- rd_data  output  NUM_RD*DATA_W  packed read data, same packing as rd_addr.
- wr_en  input  NUM_WR  per-port write enable.
- wr_addr  input  NUM_WR*ADDR_W  packed write addresses.
- wr_data  input  NUM_WR*DATA_W  packed write data.

Behaviour:
- Clock and reset: one clock (clk). Reset reset_n is asynchronous, active-low.
- reset_n low:
  - ready=0 immediately; state=CLEAR; clear index idx=0.
  - Array contents are not reset directly; the sequencer zeroes them.
- State machine: two states.
  - CLEAR: each rising edge writes mem[idx]=0 and increments idx. On the edge that writes idx=NUM_REGS-1, state goes to READY and ready=1 after that edge.
  - Ready therefore rises exactly NUM_REGS edges after reset_n deasserts.
  - READY: if clr_req=1 at an edge, state goes to CLEAR, idx=0, and ready=0 after that edge. Otherwise state stays READY.
- Writes:
  - Performed only in READY with clr_req=0.
  - Writes are dropped, not queued, in CLEAR and on the edge where clr_req is sampled.
  - Writes to address 0 are dropped.
  - If two write ports target the same address on the same edge, the higher-indexed port wins.
- Reads:
  - Combinational; rd_data[i] = mem[rd_addr[i]].
  - Address 0 always reads 0.
  - While ready=0, every read port returns 0 regardless of array contents.
- Simultaneous events:
  - reset_n asserted mid-clear restarts from idx=0.
  - clr_req while already in CLEAR is ignored; idx is not restarted.
- Out-of-range: none; NUM_REGS is a power of two, so every address is valid.
- No output is registered except ready. Read latency is 0 cycles; write latency is 1 edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read port whose address matches an enabled, accepted write port in the same cycle returns that write data combinationally.
  - Highest-indexed matching writer wins; address 0 is still 0.
  - Only accepted writes bypass (ready=1, clr_req=0).
- Undefined: reads return the stored value; new data is visible from the cycle after the write edge.

Decomposition:
- Package regfile_pkg holds:
  - enum rf_state_t {RF_CLEAR, RF_READY};
  - function addr_w(n) returning clog2;
  - localparam RF_ZERO_ADDR = 0.
- Sub-module regfile_clear_seq: owns state, idx and ready. Outputs clr_we and clr_idx.
- The top level holds the array, write arbitration and read/bypass muxing.

Test Plan:
- Reset release, defaults: ready=0 for edges 1..31 after release and 1 at edge 32. Write 0xDEADBEEF to r5 at edge 10 → dropped; r5 reads 0 after ready.
- Basic R/W: write r7=0x12345678 → rd_addr0=7 returns 0x12345678 next cycle. Write r0=0xFFFFFFFF → r0 reads 0.
- Dual writer collision (NUM_WR=2): port0 r3=0xAAAA0000 and port1 r3=0x5555FFFF on the same edge → r3 reads 0x5555FFFF.
- clr_req: with r1..r31 nonzero, pulse clr_req for one cycle → ready=0 for 32 edges, all reads 0; afterwards every register reads 0. A write on the clr_req edge is dropped.
- Async reset mid-clear: assert reset_n low at idx=12, release → ready rises exactly 32 edges after release.
- Bypass (REGFILE_BYPASS_EN defined): write r9=0xCAFEF00D while rd_addr1=9 → rd_data1=0xCAFEF00D in the same cycle. With the macro undefined, the old value is returned in that cycle.
